// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: sequences one data-memory access per instruction,
// stalls upstream while it is outstanding, and bubbles write-back on stalls or faults.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_is,
    input  logic        mem_rd_is,
    input  logic        mem_wr_is,
    input  logic [15:0] ALU_out_is,
    input  logic [15:0] wr_data_is,
    input  logic        mem_to_reg_is,
    input  logic        reg_w_en_is,
    input  logic [2:0]  w_reg_is,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] ALU_out_os,
    output logic [15:0] mem_out_os,
    output logic        mem_to_reg_os,
    output logic        reg_w_en_os,
    output logic [2:0]  w_reg_os,
    output logic        stall,
    output logic        err
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic [CW:0]   wait_inc;
    logic [15:0]   rdata_q;
    logic          mem_op;
    logic          op_legal;

    assign mem_op   = valid_is & (mem_rd_is | mem_wr_is);
    assign op_legal = ~ALU_out_is[0] & (mem_rd_is ^ mem_wr_is);
    assign wait_inc = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (state == BUSY && mem_ready && mem_rd_is)
                rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        stall       = 1'b0;
        err         = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        reg_w_en_os = 1'b0;

        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall = 1'b1;
                    if (op_legal) begin
                        state_nx    = BUSY;
                        wait_cnt_nx = '0;
                    end else begin
                        state_nx = ERR;
                    end
                end
            end
            BUSY: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = mem_wr_is;
                mem_addr  = ALU_out_is;
                mem_wdata = wr_data_is;
                // Ready in the final allowed cycle still completes the access.
                if (mem_ready) begin
                    state_nx = DONE;
                end else begin
                    wait_cnt_nx = wait_inc[CW-1:0];
                    if (wait_inc >= MAX_WAIT[CW:0])
                        state_nx = ERR;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            ERR: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (!stall)
            reg_w_en_os = reg_w_en_is & valid_is;
    end

    assign ALU_out_os    = ALU_out_is;
    assign mem_to_reg_os = mem_to_reg_is;
    assign w_reg_os      = w_reg_is;
    assign mem_out_os    = rdata_q;

endmodule
